// File: rtl/conv_window_feeder_if.sv
// rtl/conv_window_feeder_if.sv - control, memory-read and beat signals of the conv window feeder
interface conv_window_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 16
);
    logic                  start;
    logic [ADDR_W-1:0]     kernel_base;
    logic [ADDR_W-1:0]     img_base;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] data_in0;
    logic [DATA_WIDTH-1:0] data_in1;
    logic [DATA_WIDTH-1:0] data_in2;
    logic [DATA_WIDTH-1:0] data_in3;
    logic                  kernel_load;
    logic                  valid_in;
    logic                  valid_out;
    logic [7:0]            out_row;
    logic [7:0]            out_col;

    modport master (
        input  start, kernel_base, img_base, rd_data,
        output busy, done, rd_en, rd_addr,
        output data_in0, data_in1, data_in2, data_in3,
        output kernel_load, valid_in, valid_out, out_row, out_col
    );

    modport slave (
        output start, kernel_base, img_base, rd_data,
        input  busy, done, rd_en, rd_addr,
        input  data_in0, data_in1, data_in2, data_in3,
        input  kernel_load, valid_in, valid_out, out_row, out_col
    );
endinterface

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - streams a 4x4 kernel then a column-major image into the convolution unit
module conv_window_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 4,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int ADDR_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_feeder_if.master bus
);
    localparam logic [3:0] K_LAST = 4'(KERNEL_SIZE * KERNEL_SIZE - 1);
    localparam logic [1:0] J_LAST = 2'(KERNEL_SIZE - 1);
    localparam logic [7:0] R_LAST = 8'(IMG_H - 1);
    localparam logic [7:0] C_LAST = 8'(IMG_W - KERNEL_SIZE);
    localparam logic [7:0] R_WIN  = 8'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD_K, STREAM, FLUSH} state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] kb_q, ib_q, row_off;
    logic [3:0]        kcnt;
    logic [1:0]        j;
    logic [7:0]        r, c;
    logic              last_read;
    logic              issue_kern, issue_img;

    // Read-data stage: tags travel alongside each read so the beat stage knows where it belongs
    logic              d1_vld, d1_kern, d1_fin;
    logic [1:0]        d1_j;
    logic [7:0]        d1_r, d1_c;

    logic [DATA_WIDTH-1:0] p0, p1, p2;
    logic [7:0]            b_r, b_c;
    logic                  vi_fin, vo_fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue_kern = 1'b0;
        issue_img  = 1'b0;
        last_read  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = LOAD_K;
                end
            end
            LOAD_K: begin
                issue_kern = 1'b1;
                if (kcnt == K_LAST) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                issue_img = 1'b1;
                last_read = (j == J_LAST) && (r == R_LAST) && (c == C_LAST);
                if (last_read) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (vo_fin) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.busy  = (state != IDLE);
    assign bus.rd_en = issue_kern | issue_img;

    always_comb begin
        bus.rd_addr = '0;
        if (issue_kern) begin
            bus.rd_addr = kb_q + ADDR_W'(kcnt);
        end else if (issue_img) begin
            bus.rd_addr = ib_q + row_off + ADDR_W'(c) + ADDR_W'(j);
        end
    end

    // Address walk: kernel words linearly, then per column every row, four pixels per row
    always_ff @(posedge clk) begin
        if (rst) begin
            kb_q    <= '0;
            ib_q    <= '0;
            row_off <= '0;
            kcnt    <= '0;
            j       <= '0;
            r       <= '0;
            c       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        kb_q    <= bus.kernel_base;
                        ib_q    <= bus.img_base;
                        row_off <= '0;
                        kcnt    <= '0;
                        j       <= '0;
                        r       <= '0;
                        c       <= '0;
                    end
                end
                LOAD_K: kcnt <= kcnt + 4'd1;
                STREAM: begin
                    j <= j + 2'd1;
                    if (j == J_LAST) begin
                        if (r == R_LAST) begin
                            r       <= '0;
                            row_off <= '0;
                            c       <= c + 8'd1;
                        end else begin
                            r       <= r + 8'd1;
                            row_off <= row_off + ADDR_W'(IMG_W);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1_vld  <= 1'b0;
            d1_kern <= 1'b0;
            d1_fin  <= 1'b0;
            d1_j    <= '0;
            d1_r    <= '0;
            d1_c    <= '0;
        end else begin
            d1_vld  <= bus.rd_en;
            d1_kern <= issue_kern;
            d1_fin  <= last_read;
            d1_j    <= issue_kern ? kcnt[1:0] : j;
            d1_r    <= r;
            d1_c    <= c;
        end
    end

    // Beat assembly: the first three pixels wait in p0..p2, the fourth completes the beat
    always_ff @(posedge clk) begin
        if (rst) begin
            p0              <= '0;
            p1              <= '0;
            p2              <= '0;
            bus.data_in0    <= '0;
            bus.data_in1    <= '0;
            bus.data_in2    <= '0;
            bus.data_in3    <= '0;
            bus.kernel_load <= 1'b0;
            bus.valid_in    <= 1'b0;
            b_r             <= '0;
            b_c             <= '0;
            vi_fin          <= 1'b0;
        end else begin
            bus.valid_in <= d1_vld && (d1_j == J_LAST);
            vi_fin       <= d1_vld && (d1_j == J_LAST) && d1_fin;
            if (d1_vld) begin
                case (d1_j)
                    2'd0: p0 <= bus.rd_data;
                    2'd1: p1 <= bus.rd_data;
                    2'd2: p2 <= bus.rd_data;
                    default: begin
                        bus.data_in0    <= p0;
                        bus.data_in1    <= p1;
                        bus.data_in2    <= p2;
                        bus.data_in3    <= bus.rd_data;
                        bus.kernel_load <= d1_kern;
                        b_r             <= d1_r;
                        b_c             <= d1_c;
                    end
                endcase
            end
        end
    end

    // A window is complete once the beat for its bottom row has been delivered
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out <= 1'b0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
            vo_fin        <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.valid_out <= bus.valid_in && !bus.kernel_load && (b_r >= R_WIN);
            vo_fin        <= bus.valid_in && vi_fin;
            bus.done      <= vo_fin;
            if (bus.valid_in && !bus.kernel_load && (b_r >= R_WIN)) begin
                bus.out_row <= b_r - R_WIN;
                bus.out_col <= b_c;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - directed checks of conv_window_feeder on a 6x5 image
module tb_conv_window_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_feeder_if #(.DATA_WIDTH(16), .ADDR_W(16)) bus();

    conv_window_feeder #(
        .DATA_WIDTH(16), .KERNEL_SIZE(4), .IMG_W(6), .IMG_H(5), .ADDR_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[9:0]];
    end

    int errors = 0;
    int checks = 0;
    int cyc;
    int rd_cnt, first_rd_cyc, last_rd_cyc;
    logic [15:0] first_rd_addr;
    int vi_n, vo_n, done_n, done_cyc, overlap, img_n;
    int vi_cyc [64];
    logic vi_kl [64];
    logic [63:0] vi_dat [64];
    int vo_cyc [16];
    logic [7:0] vo_row [16];
    logic [7:0] vo_col [16];
    logic busy_at_done, busy_before_done, prev_busy;

    int exp_vo_cyc [6] = '{35, 39, 55, 59, 75, 79};
    logic [7:0] exp_row [6] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    logic [7:0] exp_col [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    int exp_k_cyc [4] = '{6, 10, 14, 18};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        rd_cnt = 0; first_rd_cyc = -1; last_rd_cyc = -1; first_rd_addr = '0;
        vi_n = 0; vo_n = 0; done_n = 0; done_cyc = -1; overlap = 0;
        busy_at_done = 1'bx; busy_before_done = 1'bx; prev_busy = 1'b0;
    endtask

    task automatic sample();
        if (bus.rd_en) begin
            if (rd_cnt == 0) begin
                first_rd_cyc  = cyc;
                first_rd_addr = bus.rd_addr;
            end
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (bus.valid_in && vi_n < 64) begin
            vi_cyc[vi_n] = cyc;
            vi_kl[vi_n]  = bus.kernel_load;
            vi_dat[vi_n] = {bus.data_in0, bus.data_in1, bus.data_in2, bus.data_in3};
            vi_n++;
        end
        if (bus.valid_out && vo_n < 16) begin
            vo_cyc[vo_n] = cyc;
            vo_row[vo_n] = bus.out_row;
            vo_col[vo_n] = bus.out_col;
            vo_n++;
        end
        if (bus.valid_in && bus.valid_out) overlap++;
        if (bus.done) begin
            done_n++;
            done_cyc = cyc;
            busy_at_done = bus.busy;
            busy_before_done = prev_busy;
        end
        prev_busy = bus.busy;
    endtask

    // Cycle 0 is the cycle in which start is high; sampling happens 1 time unit after each edge
    task automatic start_job();
        @(negedge clk);
        bus.start = 1'b1;
        bus.kernel_base = 16'h0100;
        bus.img_base = 16'h0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        clear_rec();
        cyc = 1;
        sample();
    endtask

    task automatic run_until_done(input int max_cyc, input int restart_at);
        while (done_n == 0 && cyc < max_cyc) begin
            bus.start = (cyc == restart_at);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cyc++;
            sample();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            sample();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.kernel_base = '0;
        bus.img_base = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[256 + i] = 16'(i + 1);
        for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 6; cc++) mem[rr * 6 + cc] = 16'(rr * 16 + cc);
        cyc = 0;
        clear_rec();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.busy, bus.done, bus.rd_en, bus.valid_in, bus.valid_out,
            bus.kernel_load, bus.out_row, bus.out_col}, 64'h0);
        chk("reset_data", {bus.data_in0, bus.data_in1, bus.data_in2, bus.data_in3}, 64'h0);

        // start together with reset must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("start_during_rst_ignored", bus.busy, 1'b0);

        // Full job
        start_job();
        run_until_done(400, -1);
        chk("first_rd_cycle", first_rd_cyc, 1);
        chk("first_rd_addr", first_rd_addr, 16'h0100);
        chk("rd_count", rd_cnt, 76);
        chk("last_rd_cycle", last_rd_cyc, 76);
        chk("beat_count", vi_n, 19);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("kbeat%0d_cycle", k), vi_cyc[k], exp_k_cyc[k]);
            chk($sformatf("kbeat%0d_kl", k), vi_kl[k], 1'b1);
        end
        chk("kbeat0_data", vi_dat[0], 64'h0001_0002_0003_0004);
        chk("kbeat3_data", vi_dat[3], 64'h000D_000E_000F_0010);
        img_n = 0;
        for (int k = 4; k < vi_n; k++) if (!vi_kl[k]) img_n++;
        chk("image_beats", img_n, 15);
        chk("img0_cycle", vi_cyc[4], 22);
        chk("img0_data", vi_dat[4], 64'h0000_0001_0002_0003);
        chk("col1_first_data", vi_dat[9], 64'h0001_0002_0003_0004);
        chk("last_img_data", vi_dat[18], 64'h0042_0043_0044_0045);
        chk("last_img_cycle", vi_cyc[18], 78);
        chk("vo_count", vo_n, 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("vo%0d_cycle", k), vo_cyc[k], exp_vo_cyc[k]);
            chk($sformatf("vo%0d_row", k), vo_row[k], exp_row[k]);
            chk($sformatf("vo%0d_col", k), vo_col[k], exp_col[k]);
        end
        chk("vi_vo_overlap", overlap, 0);
        chk("done_seen", done_n, 1);
        chk("done_cycle", done_cyc, 80);
        chk("busy_at_done", busy_at_done, 1'b0);
        chk("busy_before_done", busy_before_done, 1'b1);
        idle_cycles(4);
        chk("single_done", done_n, 1);
        chk("idle_after_done", bus.busy, 1'b0);

        // Reset in the middle of STREAM
        start_job();
        while (cyc < 40) idle_cycles(1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_outputs", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.valid_in,
            bus.valid_out, bus.kernel_load, bus.out_row, bus.out_col}, 64'h0);
        chk("midrst_data", {bus.data_in0, bus.data_in1, bus.data_in2, bus.data_in3}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        idle_cycles(6);
        chk("midrst_no_done", done_n, 0);
        chk("midrst_idle", bus.busy, 1'b0);

        // Restart, with an extra start pulsed while busy
        start_job();
        run_until_done(400, 50);
        chk("restart_first_rd_cycle", first_rd_cyc, 1);
        chk("restart_first_rd_addr", first_rd_addr, 16'h0100);
        chk("restart_vo_count", vo_n, 6);
        chk("restart_done_cycle", done_cyc, 80);
        idle_cycles(4);
        chk("restart_idle_after", bus.busy, 1'b0);
        chk("restart_single_done", done_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
